// File: rtl/mult_lastn_pkg.sv
// Shared constants for the last-N sample multiplier: FSM encoding,
// the legal window depth range and a counter-width helper.
package mult_lastn_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    localparam int D_MIN = 2;
    localparam int D_MAX = 8;

    // Width of a counter that has to reach depth-1 (never narrower than one bit)
    function automatic int cntWidth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mult_lastn_win.sv
// Window of the D most recent accepted samples, newest in the low W bits.
// Slots that have never been written since reset read as zero.
module mult_lastn_win #(
    parameter int W = 4,
    parameter int D = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift,
    input  logic [W-1:0]   din,
    output logic [W*D-1:0] win
);

    logic [W*D-1:0] win_q;

    // Shift a new sample in at slot 0 and drop the oldest one from the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (shift) begin
            win_q <= {win_q[W*D-W-1:0], din};
        end
    end

    assign win = win_q;

endmodule

// File: rtl/mult_lastn.sv
// Multiplies the last D accepted samples together, one multiply per cycle,
// and presents the full-width product with a single-cycle valid pulse.
// Samples equal to a loadable ignore value are never accepted.
module mult_lastn
    import mult_lastn_pkg::*;
#(
    parameter int           W   = 4,
    parameter int           D   = 2,
    parameter logic [W-1:0] IGN = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           ld,
    output logic [W*D-1:0] out,
    output logic           out_valid
);

    localparam int OW = W * D;
    localparam int CW = cntWidth(D);

    generate
        if (D < D_MIN || D > D_MAX) begin : gBadDepth
            $error("mult_lastn: window depth D out of range");
        end
    endgenerate

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [W-1:0]  ign_q, ign_d;
    logic [OW-1:0] out_q, out_d;
    logic          outValid_q, outValid_d;

    logic [OW-1:0] winFlat;
    logic [W-1:0]  curSample;
    logic [OW-1:0] product;
    logic          accept;

    mult_lastn_win #(
        .W(W),
        .D(D)
    ) uWin (
        .clk  (clk),
        .rst  (rst),
        .shift(accept),
        .din  (in),
        .win  (winFlat)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready && !ld && (in != ign_q);
    assign curSample = winFlat[cnt_q*W +: W];
    assign product   = acc_q * OW'(curSample);

    // Next-state logic: a load only touches the ignore value, so it can
    // overlap a running calculation; the window is read after it has shifted
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ign_d      = ign_q;
        out_d      = out_q;
        outValid_d = 1'b0;
        if (ld) begin
            ign_d = in;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d   = OW'(in);
                    cnt_d   = CW'(1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = product;
                if (cnt_q == CW'(D - 1)) begin
                    out_d      = product;
                    outValid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any calculation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            ign_q      <= IGN;
            out_q      <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ign_q      <= ign_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_mult_lastn.sv
// Bench for mult_lastn: a depth-2 and a depth-3 instance share one stimulus
// stream. Directed vector table for depth 2, hand sequences for depth 3,
// then random traffic against a history-based reference model.
module tb_mult_lastn;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] inS;
    logic         validS;
    logic         ldS;

    logic [7:0]   out2;
    logic         ov2, rdy2;
    logic [11:0]  out3;
    logic         ov3, rdy3;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mult_lastn #(.W(4), .D(2), .IGN(4'd0)) dut2 (
        .clk(clk), .rst(rst), .in(inS), .in_valid(validS), .in_ready(rdy2),
        .ld(ldS), .out(out2), .out_valid(ov2)
    );

    mult_lastn #(.W(4), .D(3), .IGN(4'd0)) dut3 (
        .clk(clk), .rst(rst), .in(inS), .in_valid(validS), .in_ready(rdy3),
        .ld(ldS), .out(out3), .out_valid(ov3)
    );

    // Reference model: remembers accepted samples and how long the block stays busy
    typedef struct {
        int unsigned     hist[8];
        int unsigned     ign;
        int              busy;
        longint unsigned outVal;
        longint unsigned pending;
        bit              outValid;
    } ModelT;

    function automatic ModelT modelReset();
        ModelT m;
        for (int i = 0; i < 8; i++) m.hist[i] = 0;
        m.ign      = 0;
        m.busy     = 0;
        m.outVal   = 0;
        m.pending  = 0;
        m.outValid = 1'b0;
        return m;
    endfunction

    function automatic ModelT modelStep(input ModelT mi, input int d, input bit l,
                                        input bit v, input int unsigned din);
        ModelT m;
        bit    ready;
        bit    acc;
        m     = mi;
        ready = (m.busy == 0);
        m.outValid = 1'b0;
        if (m.busy > 0) begin
            m.busy--;
            if (m.busy == 0) begin
                m.outVal   = m.pending;
                m.outValid = 1'b1;
            end
        end
        acc = v && ready && !l && (din != m.ign);
        if (l) m.ign = din;
        if (acc) begin
            for (int i = 7; i > 0; i--) m.hist[i] = m.hist[i-1];
            m.hist[0] = din;
            m.pending = 1;
            for (int i = 0; i < d; i++) m.pending = m.pending * m.hist[i];
            m.busy = d - 1;
        end
        return m;
    endfunction

    typedef struct {
        bit          ld;
        bit          valid;
        logic [3:0]  din;
        int unsigned expOut;
        bit          expValid;
        bit          expReady;
    } VecT;

    VecT vecs[18];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic applyStimulus(input bit l, input bit v, input logic [3:0] d);
        ldS    = l;
        validS = v;
        inS    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        ldS    = 1'b0;
        validS = 1'b0;
        inS    = '0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " out2"}, 64'(out2), 64'd0);
        checkOutput({tag, " ov2"},  64'(ov2),  64'd0);
        checkOutput({tag, " rdy2"}, 64'(rdy2), 64'd1);
        checkOutput({tag, " out3"}, 64'(out3), 64'd0);
        checkOutput({tag, " ov3"},  64'(ov3),  64'd0);
        checkOutput({tag, " rdy3"}, 64'(rdy3), 64'd1);
    endtask

    task automatic idle3(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        ModelT m2, m3;
        bit l, v;
        logic [3:0] d;

        rst    = 1'b1;
        ldS    = 1'b0;
        validS = 1'b0;
        inS    = '0;

        // Depth-2 directed table: {ld, valid, in, out, out_valid, in_ready} after each edge
        vecs[0]  = '{1'b0, 1'b1, 4'd5,  0,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0,  0,   1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 4'd10, 0,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0,  50,  1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 4'd0,  50,  1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'd5,  50,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  50,  1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 4'd10, 50,  1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'd10, 50,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 4'd13, 50,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  65,  1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 4'd7,  65,  1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'd10, 65,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  130, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 4'd7,  130, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 4'd3,  130, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 4'd4,  30,  1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 4'd0,  30,  1'b0, 1'b1};

        doReset();
        checkReset("reset");

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].valid, vecs[i].din);
            checkOutput($sformatf("vec%0d out", i),       64'(out2), 64'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d out_valid", i), 64'(ov2),  64'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d in_ready", i),  64'(rdy2), 64'(vecs[i].expReady));
        end

        // Depth-3 sequence: 2, (9 dropped while busy), 3, 4 -> 0, 0, 24
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd2);
        checkOutput("d3 ready after accept", 64'(rdy3), 64'd0);
        applyStimulus(1'b0, 1'b1, 4'd9);
        checkOutput("d3 ready busy", 64'(rdy3), 64'd0);
        checkOutput("d3 no early valid", 64'(ov3), 64'd0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("d3 first out", 64'(out3), 64'd0);
        checkOutput("d3 first valid", 64'(ov3), 64'd1);
        checkOutput("d3 ready back", 64'(rdy3), 64'd1);
        applyStimulus(1'b0, 1'b1, 4'd3);
        idle3(2);
        checkOutput("d3 second out", 64'(out3), 64'd0);
        checkOutput("d3 second valid", 64'(ov3), 64'd1);
        applyStimulus(1'b0, 1'b1, 4'd4);
        idle3(2);
        checkOutput("d3 out 24", 64'(out3), 64'd24);
        checkOutput("d3 valid 24", 64'(ov3), 64'd1);
        idle3(1);
        checkOutput("d3 hold 24", 64'(out3), 64'd24);
        checkOutput("d3 valid drop", 64'(ov3), 64'd0);

        // Full-scale window: 15*15*15 needs all 12 output bits
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd15);
            idle3(2);
        end
        checkOutput("d3 out 3375", 64'(out3), 64'd3375);

        // Reset during a calculation, after moving the ignore value to 15
        applyStimulus(1'b1, 1'b0, 4'd15);
        applyStimulus(1'b0, 1'b1, 4'd6);
        checkOutput("d3 busy before reset", 64'(rdy3), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("d3 async out", 64'(out3), 64'd0);
        checkOutput("d3 async valid", 64'(ov3), 64'd0);
        checkOutput("d3 async ready", 64'(rdy3), 64'd1);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("d3 aborted valid", 64'(ov3), 64'd0);
        checkOutput("d3 aborted out", 64'(out3), 64'd0);
        applyStimulus(1'b0, 1'b1, 4'd15);
        checkOutput("d3 ign restored", 64'(rdy3), 64'd0);
        idle3(2);
        checkOutput("d3 post-reset out", 64'(out3), 64'd0);
        checkOutput("d3 post-reset valid", 64'(ov3), 64'd1);

        // Random traffic on both depths with occasional asynchronous resets
        doReset();
        m2 = modelReset();
        m3 = modelReset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 96) == 0) begin
                rst = 1'b1;
                #1;
                checkReset("rand reset");
                #1;
                rst = 1'b0;
                m2 = modelReset();
                m3 = modelReset();
            end else begin
                l = ($urandom_range(0, 9) == 0);
                v = ($urandom_range(0, 3) != 0);
                d = 4'($urandom_range(0, 15));
                applyStimulus(l, v, d);
                m2 = modelStep(m2, 2, l, v, int'(d));
                m3 = modelStep(m3, 3, l, v, int'(d));
                checkOutput("rand d2 out",   64'(out2), 64'(m2.outVal));
                checkOutput("rand d2 valid", 64'(ov2),  64'(m2.outValid));
                checkOutput("rand d2 ready", 64'(rdy2), 64'(m2.busy == 0));
                checkOutput("rand d3 out",   64'(out3), 64'(m3.outVal));
                checkOutput("rand d3 valid", 64'(ov3),  64'(m3.outValid));
                checkOutput("rand d3 ready", 64'(rdy3), 64'(m3.busy == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
